kbonacci_gen: RTL and testbench

KBONACCI_GEN -- requirements
Module: kbonacci_gen

---
 rtl/kbonacci_gen_if.sv | 32 +++
 rtl/kbonacci_gen.sv | 155 +++++++++++++++
 tb/tb_kbonacci_gen.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kbonacci_gen_if.sv
// Handshake and payload bundle for the k-bonacci generator.
//   start/seed_a/seed_b/num_terms/stop_on_ovf : sequence request, sampled in IDLE
//   out_valid/out_ready                       : term handshake
//   out_data/out_idx                          : current term and its index
//   ovf/done                                  : sticky overflow flag, end-of-sequence pulse
// master = requester/consumer side, slave = generator side.
interface kbonacci_gen_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  start;
  logic [DATA_WIDTH-1:0] seed_a;
  logic [DATA_WIDTH-1:0] seed_b;
  logic [CNT_WIDTH-1:0]  num_terms;
  logic                  stop_on_ovf;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0]  out_idx;
  logic                  ovf;
  logic                  done;

  modport master (
    output start, seed_a, seed_b, num_terms, stop_on_ovf, out_ready,
    input  out_valid, out_data, out_idx, ovf, done
  );

  modport slave (
    input  start, seed_a, seed_b, num_terms, stop_on_ovf, out_ready,
    output out_valid, out_data, out_idx, ovf, done
  );
endinterface

// File: rtl/kbonacci_gen.sv
// K-bonacci sequence generator: emits T0..T(num_terms-1) over a valid/ready
// handshake, where each term past T1 is the sum of the previous ORDER terms.
// Ports:
//   clk    : clock, rising edge
//   resetn : synchronous active-low reset
//   bus    : kbonacci_gen_if slave (request, term stream, ovf, done)
module kbonacci_gen #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ORDER      = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic          clk,
  input  logic          resetn,
  kbonacci_gen_if.slave bus
);

  localparam int unsigned SumWidth = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                             state_q, state_d;
  // hist_q[0] is the term currently on out_data, hist_q[i] the one i steps older
  logic [ORDER-1:0][DATA_WIDTH-1:0]   hist_q, hist_d;
  logic [DATA_WIDTH-1:0]              seed_b_q, seed_b_d;
  logic [CNT_WIDTH-1:0]               num_q, num_d;
  logic [CNT_WIDTH-1:0]               idx_q, idx_d;
  logic                               stop_q, stop_d;
  logic                               valid_q, valid_d;
  logic                               ovf_q, ovf_d;
  logic                               done_q, done_d;

  logic [SumWidth-1:0]                sum_c;
  logic [DATA_WIDTH-1:0]              next_term_c;
  logic                               next_ovf_c;
  logic                               hs_c;
  logic                               last_c;

  // Running sum of the history window; zero-filled history stands in for negative indices
  for (genvar g = 0; g < ORDER; g++) begin : g_sum
    logic [SumWidth-1:0] acc;
    if (g == 0) begin : g_first
      assign acc = SumWidth'(hist_q[0]);
    end else begin : g_rest
      assign acc = g_sum[g-1].acc + SumWidth'(hist_q[g]);
    end
  end
  assign sum_c = g_sum[ORDER-1].acc;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      hist_q   <= '0;
      seed_b_q <= '0;
      num_q    <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      seed_b_q <= seed_b_d;
      num_q    <= num_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    seed_b_d = seed_b_q;
    num_d    = num_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    hs_c   = valid_q & bus.out_ready;
    last_c = (idx_q == num_q - CNT_WIDTH'(1));

    // T1 is a seed, not a sum, so the step after T0 bypasses the adder
    if (idx_q == '0) begin
      next_term_c = seed_b_q;
      next_ovf_c  = 1'b0;
    end else begin
      next_term_c = sum_c[DATA_WIDTH-1:0];
      next_ovf_c  = |sum_c[SumWidth-1:DATA_WIDTH];
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          seed_b_d = bus.seed_b;
          num_d    = bus.num_terms;
          stop_d   = bus.stop_on_ovf;
          ovf_d    = 1'b0;
          if (bus.num_terms == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = RUN;
            valid_d   = 1'b1;
            idx_d     = '0;
            hist_d    = '0;
            hist_d[0] = bus.seed_a;
          end
        end
      end
      RUN: begin
        if (hs_c) begin
          if (last_c) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else if (next_ovf_c && stop_q) begin
            // Overflowing term is withheld; the sequence ends on the last good one
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
            ovf_d   = 1'b1;
          end else begin
            idx_d  = idx_q + CNT_WIDTH'(1);
            hist_d = {hist_q[ORDER-2:0], next_term_c};
            ovf_d  = ovf_q | next_ovf_c;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = hist_q[0];
  assign bus.out_idx   = idx_q;
  assign bus.ovf       = ovf_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_kbonacci_gen.sv
// Self-checking bench for kbonacci_gen: three instances (32-bit order 2,
// 8-bit order 2, 32-bit order 3) driven by directed sequences, a per-cycle
// reference model, and literal term lists.
module tb_kbonacci_gen;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // Per-instance stimulus (index 0: fib32, 1: fib8, 2: trib32)
  logic        start_v [3];
  logic [31:0] sa_v    [3];
  logic [31:0] sb_v    [3];
  logic [15:0] nt_v    [3];
  logic        st_v    [3];
  logic        rdy_v   [3];

  // Per-instance observed outputs
  logic        dv [3];
  logic [31:0] dd [3];
  logic [15:0] di [3];
  logic        ov [3];
  logic        dn [3];

  kbonacci_gen_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) if_a ();
  kbonacci_gen_if #(.DATA_WIDTH(8),  .CNT_WIDTH(16)) if_b ();
  kbonacci_gen_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) if_c ();

  kbonacci_gen #(.DATA_WIDTH(32), .ORDER(2), .CNT_WIDTH(16)) u_fib32 (.clk(clk), .resetn(resetn), .bus(if_a));
  kbonacci_gen #(.DATA_WIDTH(8),  .ORDER(2), .CNT_WIDTH(16)) u_fib8  (.clk(clk), .resetn(resetn), .bus(if_b));
  kbonacci_gen #(.DATA_WIDTH(32), .ORDER(3), .CNT_WIDTH(16)) u_trib  (.clk(clk), .resetn(resetn), .bus(if_c));

  assign if_a.start = start_v[0];  assign if_a.seed_a = sa_v[0];      assign if_a.seed_b = sb_v[0];
  assign if_a.num_terms = nt_v[0]; assign if_a.stop_on_ovf = st_v[0]; assign if_a.out_ready = rdy_v[0];
  assign if_b.start = start_v[1];  assign if_b.seed_a = sa_v[1][7:0]; assign if_b.seed_b = sb_v[1][7:0];
  assign if_b.num_terms = nt_v[1]; assign if_b.stop_on_ovf = st_v[1]; assign if_b.out_ready = rdy_v[1];
  assign if_c.start = start_v[2];  assign if_c.seed_a = sa_v[2];      assign if_c.seed_b = sb_v[2];
  assign if_c.num_terms = nt_v[2]; assign if_c.stop_on_ovf = st_v[2]; assign if_c.out_ready = rdy_v[2];

  assign dv[0] = if_a.out_valid; assign dd[0] = if_a.out_data;          assign di[0] = if_a.out_idx;
  assign ov[0] = if_a.ovf;       assign dn[0] = if_a.done;
  assign dv[1] = if_b.out_valid; assign dd[1] = {24'd0, if_b.out_data}; assign di[1] = if_b.out_idx;
  assign ov[1] = if_b.ovf;       assign dn[1] = if_b.done;
  assign dv[2] = if_c.out_valid; assign dd[2] = if_c.out_data;          assign di[2] = if_c.out_idx;
  assign ov[2] = if_c.ovf;       assign dn[2] = if_c.done;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint m_term [3][64];
  bit     m_ovf  [3][64];
  int     m_cnt  [3];
  bit     m_fovf [3] = '{1'b0, 1'b0, 1'b0};
  int     ph     [3] = '{0, 0, 0};   // 0 idle, 1 emitting, 2 done cycle
  int     emitted[3] = '{0, 0, 0};

  // Whole sequence from the recurrence in plain arithmetic
  function automatic void model(input int k, input longint a, input longint b,
                                input int num, input bit stop);
    longint t [64];
    longint s;
    longint modv;
    int     ord;
    bit     seen;
    bit     halt;
    modv     = (k == 1) ? (longint'(1) << 8) : (longint'(1) << 32);
    ord      = (k == 2) ? 3 : 2;
    seen     = 1'b0;
    halt     = 1'b0;
    m_cnt[k] = 0;
    for (int n = 0; n < num && n < 64; n++) begin
      if (!halt) begin
        if (n == 0)      s = a;
        else if (n == 1) s = b;
        else begin
          s = 0;
          for (int j = 1; j <= ord; j++) if (n - j >= 0) s += t[n-j];
        end
        if (s >= modv && stop) halt = 1'b1;
        else begin
          seen         = seen | (s >= modv);
          t[n]         = s % modv;
          m_term[k][n] = t[n];
          m_ovf[k][n]  = seen;
          m_cnt[k]     = n + 1;
        end
      end
    end
    m_fovf[k] = seen | halt;
  endfunction

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!resetn) begin
        ph[k]     = 0;
        m_fovf[k] = 1'b0;
      end else begin
        chk($sformatf("valid%0d", k), 64'(dv[k]), 64'(ph[k] == 1));
        chk($sformatf("done%0d", k),  64'(dn[k]), 64'(ph[k] == 2));
        if (ph[k] == 1) begin
          chk($sformatf("idx%0d", k),  64'(di[k]), 64'(emitted[k]));
          chk($sformatf("data%0d", k), 64'(dd[k]), 64'(m_term[k][emitted[k]]));
          chk($sformatf("ovf%0d", k),  64'(ov[k]), 64'(m_ovf[k][emitted[k]]));
        end else begin
          chk($sformatf("ovf_hold%0d", k), 64'(ov[k]), 64'(m_fovf[k]));
        end
        case (ph[k])
          0: if (start_v[k]) begin
            model(k,
                  (k == 1) ? longint'(sa_v[k][7:0]) : longint'(sa_v[k]),
                  (k == 1) ? longint'(sb_v[k][7:0]) : longint'(sb_v[k]),
                  int'(nt_v[k]), st_v[k]);
            emitted[k] = 0;
            ph[k]      = (m_cnt[k] > 0) ? 1 : 2;
          end
          1: if (rdy_v[k]) begin
            emitted[k]++;
            if (emitted[k] == m_cnt[k]) ph[k] = 2;
          end
          default: ph[k] = 0;
        endcase
      end
    end
  end

  // ---------------- directed driver ----------------
  logic [31:0] cap_d [64];
  logic        cap_o [64];
  int          cap_n;
  logic        done_ovf_v;

  logic [31:0] fib7  [7] = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13};
  logic [31:0] trib7 [7] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd4, 32'd7, 32'd13};
  logic [31:0] trib4 [4] = '{32'd5, 32'd7, 32'd12, 32'd24};
  logic [31:0] fib3  [3] = '{32'd2, 32'd3, 32'd5};

  task automatic run_seq(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] num, input logic stop,
                         input int stall_idx, input int stall_len, input logic [31:0] stall_val);
    int stalls = 0;
    bit fin    = 1'b0;
    @(posedge clk); #1;
    start_v[k] = 1'b1; sa_v[k] = a; sb_v[k] = b; nt_v[k] = num; st_v[k] = stop; rdy_v[k] = 1'b1;
    cap_n = 0;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      if (dv[k] && int'(di[k]) == stall_idx && stalls < stall_len) begin
        rdy_v[k] = 1'b0;
        stalls++;
      end else begin
        rdy_v[k] = 1'b1;
      end
      @(negedge clk);
      if (!rdy_v[k]) begin
        chk("stall_valid", 64'(dv[k]), 64'd1);
        chk("stall_idx",   64'(di[k]), 64'(stall_idx));
        chk("stall_data",  64'(dd[k]), 64'(stall_val));
      end
      if (dv[k] && rdy_v[k] && cap_n < 64) begin
        cap_d[cap_n] = dd[k];
        cap_o[cap_n] = ov[k];
        cap_n++;
      end
      if (dn[k]) begin
        fin        = 1'b1;
        done_ovf_v = ov[k];
      end
    end
    rdy_v[k] = 1'b1;
    chk("seq_finished", 64'(fin), 64'd1);
  endtask

  initial begin
    int c;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; sa_v[k] = '0; sb_v[k] = '0; nt_v[k] = '0; st_v[k] = 1'b0; rdy_v[k] = 1'b1;
    end
    done_ovf_v = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", 64'(dv[k]), 64'd0);
      chk("rst_data",  64'(dd[k]), 64'd0);
      chk("rst_idx",   64'(di[k]), 64'd0);
      chk("rst_ovf",   64'(ov[k]), 64'd0);
      chk("rst_done",  64'(dn[k]), 64'd0);
    end

    // Fibonacci, free-running consumer
    run_seq(0, 32'd1, 32'd1, 16'd7, 1'b0, -1, 0, 32'd0);
    chk("fib_count", 64'(cap_n), 64'd7);
    for (int i = 0; i < 7; i++) chk("fib_lit", 64'(cap_d[i]), 64'(fib7[i]));
    chk("fib_done_ovf", 64'(done_ovf_v), 64'd0);

    // Same run with consumer stalled three cycles on idx 3
    run_seq(0, 32'd1, 32'd1, 16'd7, 1'b0, 3, 3, 32'd3);
    chk("stall_count", 64'(cap_n), 64'd7);
    for (int i = 0; i < 7; i++) chk("stall_lit", 64'(cap_d[i]), 64'(fib7[i]));

    // 8-bit wraparound, keep going
    run_seq(1, 32'd1, 32'd1, 16'd20, 1'b0, -1, 0, 32'd0);
    chk("wrap_count", 64'(cap_n), 64'd20);
    chk("wrap_t12",   64'(cap_d[12]), 64'd233);
    chk("wrap_o12",   64'(cap_o[12]), 64'd0);
    chk("wrap_t13",   64'(cap_d[13]), 64'd121);
    chk("wrap_o13",   64'(cap_o[13]), 64'd1);
    chk("wrap_done_ovf", 64'(done_ovf_v), 64'd1);

    // 8-bit, stop before the overflowing term
    run_seq(1, 32'd1, 32'd1, 16'd20, 1'b1, -1, 0, 32'd0);
    chk("stop_count", 64'(cap_n), 64'd13);
    chk("stop_last",  64'(cap_d[12]), 64'd233);
    chk("stop_done_ovf", 64'(done_ovf_v), 64'd1);

    // New start clears the sticky flag
    run_seq(1, 32'd2, 32'd3, 16'd3, 1'b0, -1, 0, 32'd0);
    chk("clr_count", 64'(cap_n), 64'd3);
    for (int i = 0; i < 3; i++) chk("clr_lit", 64'(cap_d[i]), 64'(fib3[i]));
    chk("clr_done_ovf", 64'(done_ovf_v), 64'd0);

    // Tribonacci
    run_seq(2, 32'd0, 32'd1, 16'd7, 1'b0, -1, 0, 32'd0);
    chk("trib_count", 64'(cap_n), 64'd7);
    for (int i = 0; i < 7; i++) chk("trib_lit", 64'(cap_d[i]), 64'(trib7[i]));
    run_seq(2, 32'd5, 32'd7, 16'd4, 1'b0, 1, 2, 32'd7);
    chk("trib4_count", 64'(cap_n), 64'd4);
    for (int i = 0; i < 4; i++) chk("trib4_lit", 64'(cap_d[i]), 64'(trib4[i]));

    // Reset in the middle of a run, with start asserted on the reset edge
    @(posedge clk); #1;
    start_v[0] = 1'b1; sa_v[0] = 32'd1; sb_v[0] = 32'd1; nt_v[0] = 16'd7; st_v[0] = 1'b0; rdy_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    for (c = 0; c < 20 && !(dv[0] && di[0] == 16'd4); c++) begin
      @(posedge clk); #1;
    end
    chk("reach_idx4", 64'(dv[0] && di[0] == 16'd4), 64'd1);
    resetn = 1'b0; start_v[0] = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b1; start_v[0] = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 64'(dv[0]), 64'd0);
    chk("mrst_data",  64'(dd[0]), 64'd0);
    chk("mrst_idx",   64'(di[0]), 64'd0);
    chk("mrst_ovf",   64'(ov[0]), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_start_ignored", 64'(dv[0] | dn[0]), 64'd0);
    run_seq(0, 32'd1, 32'd1, 16'd7, 1'b0, -1, 0, 32'd0);
    chk("restart_count", 64'(cap_n), 64'd7);
    for (int i = 0; i < 7; i++) chk("restart_lit", 64'(cap_d[i]), 64'(fib7[i]));

    // Zero-length request, start held through the DONE cycle
    @(posedge clk); #1;
    start_v[0] = 1'b1; nt_v[0] = 16'd0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_done",  64'(dn[0]), 64'd1);
    chk("zero_valid", 64'(dv[0]), 64'd0);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(negedge clk);
    chk("zero_done_once", 64'(dn[0]), 64'd0);
    chk("zero_valid2",    64'(dv[0]), 64'd0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
